// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolution with a direct-mapped table of 2-bit saturating counters.
// Latency: flush/redirect one cycle after resolve. Backpressure: none, resolves every cycle.
module branch_resolve_bht #(
    parameter int IDX_BITS = 6,
    parameter int PC_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [1:0]        ex_br_type,
    input  logic              ex_zero_flag,
    input  logic [31:0]       ex_alu_result,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [PC_W-1:0]   ex_imm,
    input  logic              ex_pred_taken,
    output logic              flush,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [31:0]       branch_count,
    output logic [31:0]       mispredict_count
);

    localparam int ENTRIES = 2 ** IDX_BITS;

    logic [1:0]          bht_q [ENTRIES];
    logic                flush_q, flush_d;
    logic [PC_W-1:0]     redirect_pc_q, redirect_pc_d;
    logic [31:0]         branch_count_q, branch_count_d;
    logic [31:0]         mispredict_count_q, mispredict_count_d;

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic                res, dir, taken, mispredict;
    logic [PC_W-1:0]     target;
    logic [1:0]          ctr_cur, ctr_d;

    assign if_idx = if_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];

    // Pre-update read: a same-cycle write to this entry lands at the next edge.
    assign if_pred_taken = bht_q[if_idx][1];

    always_comb begin
        res = ex_valid & ex_is_branch & ~flush_q;
        case (ex_br_type)
            2'b00:   dir = ex_zero_flag;
            2'b01:   dir = ~ex_zero_flag;
            2'b10:   dir = ex_alu_result[0];
            default: dir = ~ex_alu_result[0];
        endcase
        // Gating with res keeps floating EX operands out of every state path.
        taken      = res & dir;
        mispredict = res & (taken != ex_pred_taken);
        target     = taken ? (ex_pc + ex_imm) : (ex_pc + PC_W'(4));

        ctr_cur = bht_q[ex_idx];
        ctr_d   = ctr_cur;
        if (taken && ctr_cur != 2'b11)
            ctr_d = ctr_cur + 2'd1;
        else if (!taken && ctr_cur != 2'b00)
            ctr_d = ctr_cur - 2'd1;

        flush_d            = mispredict;
        redirect_pc_d      = mispredict ? target : redirect_pc_q;
        branch_count_d     = branch_count_q + 32'(res);
        mispredict_count_d = mispredict_count_q + 32'(mispredict);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                bht_q[i] <= 2'b01;
            flush_q            <= 1'b0;
            redirect_pc_q      <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (res)
                bht_q[ex_idx] <= ctr_d;
            flush_q            <= flush_d;
            redirect_pc_q      <= redirect_pc_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Reset held in the cycle after a mispredict cancels the pending redirect.
    assign flush            = flush_q & ~reset;
    assign redirect_valid   = flush_q & ~reset;
    assign redirect_pc      = redirect_pc_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

    logic unused_bits;
    assign unused_bits = ^{if_pc[PC_W-1:IDX_BITS+2], if_pc[1:0], ex_alu_result[31:1]};

endmodule
